uart_fifo_loop: RTL

Byte buffer and transmit sequencer between `uart_recv` and `uart_send` in the UART loopback path. Received bytes are captured on `recv_done` into an internal FIFO. They are replayed in order to `uart_send` through its `uart_en`/`uart_tx_busy` handshake. This lets a PC burst bytes back-to-back without losing any while the transmitter is still busy.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_fifo_loop.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART loopback types: transmit sequencer states, byte width and a
// saturating counter helper.
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_IDLE
    } tx_state_e;

    // Adds 0..2 to an 8-bit count, clamping at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] val, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, val} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port; occupancy is tracked
// directly in a counter so full/empty need no extra pointer bit.
module sync_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int DW     = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DW-1:0]     wdata,
    input  logic              rd_en,
    output logic [DW-1:0]     rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [DW-1:0]     mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [DW-1:0]     rdata_q;
    logic              do_wr, do_rd;

    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // NOTE: storage has no reset; only pointers and count define valid
    // contents, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // NOTE: non-blocking assignments here let a full-FIFO write and pop in
    // the same cycle read the old word at the shared address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                rdata_q  <= mem_q[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign count = count_q;

endmodule

// File: rtl/uart_fifo_loop.sv
// Buffers bytes from uart_recv and replays them in order to uart_send via
// the send_en / tx_busy handshake, abandoning a byte if busy never appears.
module uart_fifo_loop
    import uart_pkg::*;
#(
    parameter  int DEPTH        = 16,
    localparam int ADDR_W       = $clog2(DEPTH),
    parameter  int BUSY_TIMEOUT = 255
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                recv_done,
    input  logic [UART_DW-1:0]  recv_data,
    input  logic                tx_busy,
    output logic                send_en,
    output logic [UART_DW-1:0]  send_data,
    output logic [ADDR_W:0]     fifo_count,
    output logic                overflow,
    output logic [7:0]          drop_cnt
);

    tx_state_e          state_q, state_d;
    logic [15:0]        tmo_cnt_q, tmo_cnt_d;
    logic               send_en_q, send_en_d;
    logic [UART_DW-1:0] send_data_q, send_data_d;
    logic               recv_done_q;
    logic               overflow_q;
    logic [7:0]         drop_cnt_q;

    logic               wr_req, wr_accept, drop_ovf, timeout, rd_en;
    logic               fifo_full, fifo_empty;
    logic [UART_DW-1:0] fifo_rdata;
    logic [1:0]         drop_inc;

    // A write may still land on a full FIFO when the sequencer pops that cycle.
    assign wr_req    = recv_done & ~recv_done_q;
    assign wr_accept = wr_req & (~fifo_full | rd_en);
    assign drop_ovf  = wr_req & ~wr_accept;
    assign drop_inc  = {1'b0, drop_ovf} + {1'b0, timeout};

    sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (UART_DW)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .wr_en (wr_accept),
        .wdata (recv_data),
        .rd_en (rd_en),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every signal driven here gets a default first so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        send_en_d   = send_en_q;
        send_data_d = send_data_q;
        rd_en       = 1'b0;
        timeout     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    rd_en   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                send_data_d = fifo_rdata;
                send_en_d   = 1'b1;
                tmo_cnt_d   = '0;
                state_d     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    send_en_d = 1'b0;
                    state_d   = WAIT_IDLE;
                end else if (tmo_cnt_q == 16'(BUSY_TIMEOUT)) begin
                    send_en_d = 1'b0;
                    timeout   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            WAIT_IDLE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            send_en_q   <= 1'b0;
            send_data_q <= '0;
            recv_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            send_en_q   <= send_en_d;
            send_data_q <= send_data_d;
            recv_done_q <= recv_done;
            overflow_q  <= drop_ovf;
            drop_cnt_q  <= sat_add8(drop_cnt_q, drop_inc);
        end
    end

    assign send_en   = send_en_q;
    assign send_data = send_data_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
